// File: rtl/ex_pipe_fwd.sv
// Execute-path pipeline (ID -> EX -> MEM -> WB) with EX/MEM and MEM/WB operand forwarding,
// a one-cycle load-use interlock, and a stall-only mode when forwarding is disabled.
module ex_pipe_fwd #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned RAW    = $clog2(NREGS),
    parameter bit          FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RAW-1:0]  in_rs1,
    input  logic [RAW-1:0]  in_rs2,
    input  logic [RAW-1:0]  in_rd,
    input  logic [2:0]      in_op,
    input  logic            in_use_imm,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_regwrite,
    input  logic            in_memread,
    input  logic            in_memwrite,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_we,
    output logic            mem_re,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic [RAW-1:0]  wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            ex_zero
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic [XLEN-1:0] regs_q [NREGS];

    logic            idex_valid_q, idex_regwrite_q, idex_memread_q, idex_memwrite_q;
    logic            idex_use_imm_q;
    logic [RAW-1:0]  idex_rs1_q, idex_rs2_q, idex_rd_q;
    logic [2:0]      idex_op_q;
    logic [XLEN-1:0] idex_imm_q, idex_a_q, idex_b_q;

    logic            exmem_valid_q, exmem_regwrite_q, exmem_memread_q, exmem_memwrite_q;
    logic [RAW-1:0]  exmem_rd_q;
    logic [XLEN-1:0] exmem_alu_q, exmem_store_q;

    logic            memwb_valid_q, memwb_regwrite_q;
    logic [RAW-1:0]  memwb_rd_q;
    logic [XLEN-1:0] memwb_data_q;

    logic            wb_we, rs2_used, idex_match, exmem_match, stall, fire, exmem_fwd_ok;
    logic [XLEN-1:0] id_a, id_b, ex_a, ex_rs2, ex_b, ex_alu;

    assign wb_we = memwb_valid_q && memwb_regwrite_q && (memwb_rd_q != '0);

    // Register read with same-cycle WB bypass; x0 always reads zero.
    always_comb begin
        id_a = '0;
        id_b = '0;
        if (in_rs1 != '0) id_a = (wb_we && (memwb_rd_q == in_rs1)) ? memwb_data_q : regs_q[in_rs1];
        if (in_rs2 != '0) id_b = (wb_we && (memwb_rd_q == in_rs2)) ? memwb_data_q : regs_q[in_rs2];
    end

    // rs2 is only ignored for immediate ALU ops and loads.
    assign rs2_used    = !in_use_imm || in_memwrite;
    assign idex_match  = (idex_rd_q != '0) &&
                         ((in_rs1 == idex_rd_q) || (rs2_used && (in_rs2 == idex_rd_q)));
    assign exmem_match = (exmem_rd_q != '0) &&
                         ((in_rs1 == exmem_rd_q) || (rs2_used && (in_rs2 == exmem_rd_q)));

    always_comb begin
        stall = 1'b0;
        if (FWD_EN) begin
            stall = idex_valid_q && idex_memread_q && idex_match;
        end else begin
            stall = (idex_valid_q && idex_regwrite_q && idex_match) ||
                    (exmem_valid_q && exmem_regwrite_q && exmem_match);
        end
    end

    assign in_ready = reset && !stall;
    assign fire     = in_valid && in_ready;

    // Loads in EX/MEM have no data yet; the interlock covers that case.
    assign exmem_fwd_ok = FWD_EN && exmem_valid_q && exmem_regwrite_q && !exmem_memread_q &&
                          (exmem_rd_q != '0);

    always_comb begin
        ex_a   = idex_a_q;
        ex_rs2 = idex_b_q;
        if (exmem_fwd_ok && (exmem_rd_q == idex_rs1_q)) begin
            ex_a = exmem_alu_q;
        end else if (FWD_EN && wb_we && (memwb_rd_q == idex_rs1_q)) begin
            ex_a = memwb_data_q;
        end
        if (exmem_fwd_ok && (exmem_rd_q == idex_rs2_q)) begin
            ex_rs2 = exmem_alu_q;
        end else if (FWD_EN && wb_we && (memwb_rd_q == idex_rs2_q)) begin
            ex_rs2 = memwb_data_q;
        end
        ex_b = idex_use_imm_q ? idex_imm_q : ex_rs2;
    end

    always_comb begin
        ex_alu = '0;
        unique case (idex_op_q)
            3'd0: ex_alu = ex_a + ex_b;
            3'd1: ex_alu = ex_a - ex_b;
            3'd2: ex_alu = ex_a & ex_b;
            3'd3: ex_alu = ex_a | ex_b;
            3'd4: ex_alu = ex_a ^ ex_b;
            3'd5: ex_alu = {{(XLEN-1){1'b0}}, ($signed(ex_a) < $signed(ex_b))};
            3'd6: ex_alu = ex_a << ex_b[SHW-1:0];
            3'd7: ex_alu = ex_a >> ex_b[SHW-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
            idex_valid_q     <= 1'b0;
            idex_regwrite_q  <= 1'b0;
            idex_memread_q   <= 1'b0;
            idex_memwrite_q  <= 1'b0;
            idex_use_imm_q   <= 1'b0;
            idex_rs1_q       <= '0;
            idex_rs2_q       <= '0;
            idex_rd_q        <= '0;
            idex_op_q        <= '0;
            idex_imm_q       <= '0;
            idex_a_q         <= '0;
            idex_b_q         <= '0;
            exmem_valid_q    <= 1'b0;
            exmem_regwrite_q <= 1'b0;
            exmem_memread_q  <= 1'b0;
            exmem_memwrite_q <= 1'b0;
            exmem_rd_q       <= '0;
            exmem_alu_q      <= '0;
            exmem_store_q    <= '0;
            memwb_valid_q    <= 1'b0;
            memwb_regwrite_q <= 1'b0;
            memwb_rd_q       <= '0;
            memwb_data_q     <= '0;
        end else begin
            if (wb_we) regs_q[memwb_rd_q] <= memwb_data_q;

            idex_valid_q     <= fire;
            idex_regwrite_q  <= fire && in_regwrite;
            idex_memread_q   <= fire && in_memread;
            idex_memwrite_q  <= fire && in_memwrite;
            idex_use_imm_q   <= in_use_imm;
            idex_rs1_q       <= in_rs1;
            idex_rs2_q       <= in_rs2;
            idex_rd_q        <= in_rd;
            idex_op_q        <= in_op;
            idex_imm_q       <= in_imm;
            idex_a_q         <= id_a;
            idex_b_q         <= id_b;

            exmem_valid_q    <= idex_valid_q;
            exmem_regwrite_q <= idex_regwrite_q;
            exmem_memread_q  <= idex_memread_q;
            exmem_memwrite_q <= idex_memwrite_q;
            exmem_rd_q       <= idex_rd_q;
            exmem_alu_q      <= ex_alu;
            exmem_store_q    <= ex_rs2;

            memwb_valid_q    <= exmem_valid_q;
            memwb_regwrite_q <= exmem_regwrite_q;
            memwb_rd_q       <= exmem_rd_q;
            memwb_data_q     <= exmem_memread_q ? mem_rdata : exmem_alu_q;
        end
    end

    assign mem_addr  = exmem_alu_q;
    assign mem_wdata = exmem_store_q;
    assign mem_we    = reset && exmem_valid_q && exmem_memwrite_q;
    assign mem_re    = reset && exmem_valid_q && exmem_memread_q;
    assign wb_valid  = reset && memwb_valid_q;
    assign wb_rd     = memwb_rd_q;
    assign wb_data   = memwb_data_q;
    assign ex_zero   = reset && idex_valid_q && (ex_alu == '0);

endmodule

// File: tb/tb_ex_pipe_fwd.sv
// Bench for ex_pipe_fwd: directed cycle tables for both modes, a mid-flight reset sequence,
// and random issue streams checked against an in-order architectural model.
module tb_ex_pipe_fwd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, sel;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [2:0]  in_op;
    logic        in_use_imm, in_regwrite, in_memread, in_memwrite;
    logic [31:0] in_imm;

    logic        v_a, rdy_a, we_a, re_a, wbv_a, ez_a;
    logic [31:0] addr_a, wd_a, rdata_a, wbd_a;
    logic [4:0]  wbrd_a;
    logic        v_b, rdy_b, we_b, re_b, wbv_b, ez_b;
    logic [31:0] addr_b, wd_b, rdata_b, wbd_b;
    logic [4:0]  wbrd_b;

    logic [31:0] tbmem [64];

    assign v_a     = in_valid && sel;
    assign v_b     = in_valid && !sel;
    assign rdata_a = tbmem[addr_a[7:2]];
    assign rdata_b = tbmem[addr_b[7:2]];

    always @(posedge clk) begin
        if (we_a) tbmem[addr_a[7:2]] <= wd_a;
        if (we_b) tbmem[addr_b[7:2]] <= wd_b;
    end

    ex_pipe_fwd #(.XLEN(32), .NREGS(32), .FWD_EN(1'b1)) dut_fwd (
        .clk(clk), .reset(reset), .in_valid(v_a), .in_ready(rdy_a),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_op(in_op),
        .in_use_imm(in_use_imm), .in_imm(in_imm), .in_regwrite(in_regwrite),
        .in_memread(in_memread), .in_memwrite(in_memwrite),
        .mem_addr(addr_a), .mem_wdata(wd_a), .mem_we(we_a), .mem_re(re_a),
        .mem_rdata(rdata_a), .wb_valid(wbv_a), .wb_rd(wbrd_a), .wb_data(wbd_a),
        .ex_zero(ez_a)
    );

    ex_pipe_fwd #(.XLEN(32), .NREGS(32), .FWD_EN(1'b0)) dut_nofwd (
        .clk(clk), .reset(reset), .in_valid(v_b), .in_ready(rdy_b),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_op(in_op),
        .in_use_imm(in_use_imm), .in_imm(in_imm), .in_regwrite(in_regwrite),
        .in_memread(in_memread), .in_memwrite(in_memwrite),
        .mem_addr(addr_b), .mem_wdata(wd_b), .mem_we(we_b), .mem_re(re_b),
        .mem_rdata(rdata_b), .wb_valid(wbv_b), .wb_rd(wbrd_b), .wb_data(wbd_b),
        .ex_zero(ez_b)
    );

    // Outputs of whichever instance is currently being exercised.
    logic        m_rdy, m_we, m_re, m_wbv, m_ez;
    logic [31:0] m_addr, m_wd, m_wbd;
    logic [4:0]  m_wbrd;
    assign m_rdy  = sel ? rdy_a  : rdy_b;
    assign m_we   = sel ? we_a   : we_b;
    assign m_re   = sel ? re_a   : re_b;
    assign m_wbv  = sel ? wbv_a  : wbv_b;
    assign m_ez   = sel ? ez_a   : ez_b;
    assign m_addr = sel ? addr_a : addr_b;
    assign m_wd   = sel ? wd_a   : wd_b;
    assign m_wbd  = sel ? wbd_a  : wbd_b;
    assign m_wbrd = sel ? wbrd_a : wbrd_b;

    typedef struct {
        logic [31:0] v, rs1, rs2, rd, op, ui, imm, rw, mr, mw;
    } ins_t;

    typedef struct {
        ins_t        i;
        logic [31:0] rdy, wbv, wbrd, wbd, we, re, addr, wd;
    } row_t;

    int   total = 0;
    int   bad   = 0;
    row_t tbl [16];
    int   nrows;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic ins_t mk(input int unsigned v, rs1, rs2, rd, op, ui, imm, rw, mr, mw);
        ins_t t;
        t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.op = op;
        t.ui = ui; t.imm = imm; t.rw = rw; t.mr = mr; t.mw = mw;
        return t;
    endfunction

    function automatic ins_t nop_i();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic ins_t addi(input int unsigned rd, rs1, imm);
        return mk(1, rs1, 0, rd, 0, 1, imm, 1, 0, 0);
    endfunction
    function automatic ins_t rr(input int unsigned op, rd, rs1, rs2);
        return mk(1, rs1, rs2, rd, op, 0, 0, 1, 0, 0);
    endfunction
    function automatic ins_t lw(input int unsigned rd, rs1, imm);
        return mk(1, rs1, 0, rd, 0, 1, imm, 1, 1, 0);
    endfunction
    function automatic ins_t sw(input int unsigned rs2, rs1, imm);
        return mk(1, rs1, rs2, 0, 0, 1, imm, 0, 0, 1);
    endfunction

    function automatic row_t rw_(input ins_t i, input int unsigned rdy, wbv, wbrd, wbd,
                                 input int unsigned we, re, addr, wd);
        row_t r;
        r.i = i; r.rdy = rdy; r.wbv = wbv; r.wbrd = wbrd; r.wbd = wbd;
        r.we = we; r.re = re; r.addr = addr; r.wd = wd;
        return r;
    endfunction

    task automatic drive(input ins_t i);
        in_valid    = i.v[0];
        in_rs1      = i.rs1[4:0];
        in_rs2      = i.rs2[4:0];
        in_rd       = i.rd[4:0];
        in_op       = i.op[2:0];
        in_use_imm  = i.ui[0];
        in_imm      = i.imm;
        in_regwrite = i.rw[0];
        in_memread  = i.mr[0];
        in_memwrite = i.mw[0];
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        drive(nop_i());
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic apply_row(input row_t r, input string tag);
        @(posedge clk);
        #1 drive(r.i);
        @(negedge clk);
        chk({tag, ".in_ready"}, {31'b0, m_rdy}, r.rdy);
        chk({tag, ".wb_valid"}, {31'b0, m_wbv}, r.wbv);
        if (r.wbv != 0) begin
            chk({tag, ".wb_rd"}, {27'b0, m_wbrd}, r.wbrd);
            chk({tag, ".wb_data"}, m_wbd, r.wbd);
        end
        chk({tag, ".mem_we"}, {31'b0, m_we}, r.we);
        chk({tag, ".mem_re"}, {31'b0, m_re}, r.re);
        if (r.we != 0 || r.re != 0) chk({tag, ".mem_addr"}, m_addr, r.addr);
        if (r.we != 0) chk({tag, ".mem_wdata"}, m_wd, r.wd);
    endtask

    task automatic run_table(input string nm);
        for (int k = 0; k < nrows; k++) apply_row(tbl[k], $sformatf("%s[%0d]", nm, k));
    endtask

    function automatic logic [31:0] alu_ref(input logic [31:0] op, a, b);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6: return a << b[4:0];
            7: return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    // True when producer p writes a register that consumer q actually reads.
    function automatic logic src_hit(input ins_t p, input ins_t q);
        logic uses2;
        uses2 = (q.ui[0] == 1'b0) || q.mw[0];
        return (p.rd != 0) && ((q.rs1 == p.rd) || (uses2 && (q.rs2 == p.rd)));
    endfunction

    function automatic ins_t rand_ins();
        int unsigned kind, v, rs1, rs2, rd, op, imm;
        kind = $urandom_range(0, 9);
        v    = ($urandom_range(0, 9) < 8) ? 1 : 0;
        rs1  = $urandom_range(0, 7);
        rs2  = $urandom_range(0, 7);
        rd   = $urandom_range(0, 7);
        op   = $urandom_range(0, 7);
        imm  = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 31);
        if (kind <= 3)      return mk(v, rs1, rs2, rd, op, 0, $urandom, 1, 0, 0);
        else if (kind <= 5) return mk(v, rs1, rs2, rd, op, 1, imm, 1, 0, 0);
        else if (kind <= 7) return mk(v, rs1, rs2, rd, 0, 1, $urandom_range(0, 255), 1, 1, 0);
        else if (kind == 8) return mk(v, rs1, rs2, 0, 0, 1, $urandom_range(0, 255), 0, 0, 1);
        else                return mk(v, rs1, rs2, rd, op, $urandom_range(0, 1), imm, 0, 0, 0);
    endfunction

    // Architectural model: each accepted instruction executes in program order at issue and
    // schedules its observable effects 1 (ex_zero), 2 (memory) and 3 (retire) cycles later.
    task automatic run_random(input int ncyc, input string nm);
        logic [31:0] mregs [32];
        logic [31:0] mm [64];
        logic [31:0] s_wbv [8], s_rd [8], s_d [8], s_ez [8];
        logic [31:0] s_we [8], s_re [8], s_ad [8], s_wd [8];
        ins_t        cur, h1, h2;
        logic        hold, stall, acc;
        logic [31:0] a, b2, b, alu, res;
        int          k;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        for (int i = 0; i < 64; i++) mm[i] = tbmem[i];
        for (int i = 0; i < 8; i++) begin
            s_wbv[i] = 0; s_rd[i] = 0; s_d[i] = 0; s_ez[i] = 0;
            s_we[i] = 0; s_re[i] = 0; s_ad[i] = 0; s_wd[i] = 0;
        end
        h1 = nop_i(); h2 = nop_i(); cur = nop_i(); hold = 1'b0;
        for (int c = 0; c < ncyc + 8; c++) begin
            @(posedge clk);
            #1;
            if (!hold) cur = (c < ncyc) ? rand_ins() : nop_i();
            drive(cur);
            @(negedge clk);
            if (sel) stall = h1.v[0] && h1.mr[0] && src_hit(h1, cur);
            else     stall = (h1.v[0] && h1.rw[0] && src_hit(h1, cur)) ||
                             (h2.v[0] && h2.rw[0] && src_hit(h2, cur));
            chk({nm, ".in_ready"}, {31'b0, m_rdy}, {31'b0, !stall});
            k = c % 8;
            chk({nm, ".wb_valid"}, {31'b0, m_wbv}, s_wbv[k]);
            if (s_wbv[k] != 0) begin
                chk({nm, ".wb_rd"}, {27'b0, m_wbrd}, s_rd[k]);
                chk({nm, ".wb_data"}, m_wbd, s_d[k]);
            end
            chk({nm, ".ex_zero"}, {31'b0, m_ez}, s_ez[k]);
            chk({nm, ".mem_we"}, {31'b0, m_we}, s_we[k]);
            chk({nm, ".mem_re"}, {31'b0, m_re}, s_re[k]);
            if (s_we[k] != 0 || s_re[k] != 0) chk({nm, ".mem_addr"}, m_addr, s_ad[k]);
            if (s_we[k] != 0) chk({nm, ".mem_wdata"}, m_wd, s_wd[k]);
            s_wbv[k] = 0; s_ez[k] = 0; s_we[k] = 0; s_re[k] = 0;

            acc  = cur.v[0] && m_rdy;
            hold = cur.v[0] && !m_rdy;
            if (acc) begin
                a   = mregs[cur.rs1[4:0]];
                b2  = mregs[cur.rs2[4:0]];
                b   = cur.ui[0] ? cur.imm : b2;
                alu = alu_ref(cur.op, a, b);
                res = cur.mr[0] ? mm[alu[7:2]] : alu;
                if (cur.mw[0]) mm[alu[7:2]] = b2;
                if (cur.rw[0] && cur.rd != 0) mregs[cur.rd[4:0]] = res;
                s_ez[(c + 1) % 8]  = (alu == 0) ? 1 : 0;
                s_we[(c + 2) % 8]  = cur.mw;
                s_re[(c + 2) % 8]  = cur.mr;
                s_ad[(c + 2) % 8]  = alu;
                s_wd[(c + 2) % 8]  = b2;
                s_wbv[(c + 3) % 8] = 1;
                s_rd[(c + 3) % 8]  = cur.rd;
                s_d[(c + 3) % 8]   = res;
            end
            h2 = h1;
            h1 = acc ? cur : nop_i();
        end
    endtask

    initial begin
        reset = 1'b0;
        sel   = 1'b1;
        drive(nop_i());

        // Forwarding mode: forwards, load-use stall, x0 handling.
        do_reset();
        tbl[0]  = rw_(addi(1, 0, 5),        1, 0, 0, 0,           0, 0, 0,  0);
        tbl[1]  = rw_(addi(2, 0, 7),        1, 0, 0, 0,           0, 0, 0,  0);
        tbl[2]  = rw_(rr(0, 3, 1, 2),       1, 0, 0, 0,           0, 0, 0,  0);
        tbl[3]  = rw_(rr(1, 4, 3, 1),       1, 1, 1, 5,           0, 0, 0,  0);
        tbl[4]  = rw_(addi(8, 0, 'hDEAD),   1, 1, 2, 7,           0, 0, 0,  0);
        tbl[5]  = rw_(sw(8, 0, 16),         1, 1, 3, 12,          0, 0, 0,  0);
        tbl[6]  = rw_(lw(5, 0, 16),         1, 1, 4, 7,           0, 0, 0,  0);
        tbl[7]  = rw_(rr(0, 6, 5, 5),       0, 1, 8, 'hDEAD,      1, 0, 16, 'hDEAD);
        tbl[8]  = rw_(rr(0, 6, 5, 5),       1, 1, 0, 16,          0, 1, 16, 0);
        tbl[9]  = rw_(addi(0, 0, 9),        1, 1, 5, 'hDEAD,      0, 0, 0,  0);
        tbl[10] = rw_(rr(0, 7, 0, 0),       1, 0, 0, 0,           0, 0, 0,  0);
        tbl[11] = rw_(nop_i(),              1, 1, 6, 'h1BD5A,     0, 0, 0,  0);
        tbl[12] = rw_(nop_i(),              1, 1, 0, 9,           0, 0, 0,  0);
        tbl[13] = rw_(nop_i(),              1, 1, 7, 0,           0, 0, 0,  0);
        tbl[14] = rw_(nop_i(),              1, 0, 0, 0,           0, 0, 0,  0);
        nrows = 15;
        run_table("fwd");

        // Reset with three instructions in flight: none may retire or write.
        apply_row(rw_(addi(9, 0, 1),  1, 0, 0, 0, 0, 0, 0, 0), "mid.i0");
        apply_row(rw_(addi(10, 0, 2), 1, 0, 0, 0, 0, 0, 0, 0), "mid.i1");
        apply_row(rw_(addi(11, 0, 3), 1, 0, 0, 0, 0, 0, 0, 0), "mid.i2");
        @(posedge clk);
        #1 reset = 1'b0;
        drive(addi(12, 0, 4));
        @(negedge clk);
        chk("mid.rst.in_ready", {31'b0, m_rdy}, 32'd0);
        chk("mid.rst.wb_valid", {31'b0, m_wbv}, 32'd0);
        chk("mid.rst.mem_we", {31'b0, m_we}, 32'd0);
        chk("mid.rst.mem_re", {31'b0, m_re}, 32'd0);
        chk("mid.rst.ex_zero", {31'b0, m_ez}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        drive(nop_i());
        for (int k = 0; k < 3; k++)
            apply_row(rw_(nop_i(), 1, 0, 0, 0, 0, 0, 0, 0), $sformatf("mid.idle%0d", k));
        apply_row(rw_(rr(0, 12, 1, 9), 1, 0, 0, 0, 0, 0, 0, 0), "mid.rd0");
        apply_row(rw_(rr(0, 13, 3, 8), 1, 0, 0, 0, 0, 0, 0, 0), "mid.rd1");
        apply_row(rw_(nop_i(),         1, 0, 0, 0, 0, 0, 0, 0), "mid.rd2");
        apply_row(rw_(nop_i(),         1, 1, 12, 0, 0, 0, 0, 0), "mid.rd3");
        apply_row(rw_(nop_i(),         1, 1, 13, 0, 0, 0, 0, 0), "mid.rd4");

        do_reset();
        run_random(500, "rnd_fwd");

        // Stall-only mode.
        sel = 1'b0;
        do_reset();
        tbl[0] = rw_(addi(1, 0, 3),   1, 0, 0, 0, 0, 0, 0, 0);
        tbl[1] = rw_(rr(0, 2, 1, 1),  0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2] = rw_(rr(0, 2, 1, 1),  0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3] = rw_(rr(0, 2, 1, 1),  1, 1, 1, 3, 0, 0, 0, 0);
        tbl[4] = rw_(addi(3, 0, 1),   1, 0, 0, 0, 0, 0, 0, 0);
        tbl[5] = rw_(addi(4, 0, 2),   1, 0, 0, 0, 0, 0, 0, 0);
        tbl[6] = rw_(nop_i(),         1, 1, 2, 6, 0, 0, 0, 0);
        tbl[7] = rw_(nop_i(),         1, 1, 3, 1, 0, 0, 0, 0);
        tbl[8] = rw_(nop_i(),         1, 1, 4, 2, 0, 0, 0, 0);
        nrows = 9;
        run_table("nofwd");

        do_reset();
        run_random(500, "rnd_nofwd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
